// File: rtl/kl_dispatcher.sv
// Key-lock bus dispatcher: sweeps a unique {row,col} lock tag into every PE, then
// broadcasts accepted key commands for KEY_HOLD cycles. Optional row-sweep: KL_DISPATCH_BCAST_EN.
module kl_dispatcher #(
    parameter int ROW_W    = 2,
    parameter int COL_W    = 2,
    parameter int NUM_ROWS = 3,
    parameter int NUM_COLS = 3,
    parameter int KEY_HOLD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_start,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ROW_W-1:0]         cmd_row,
    input  logic [COL_W-1:0]         cmd_col,
`ifdef KL_DISPATCH_BCAST_EN
    input  logic                     cmd_bcast,
`endif
    output logic                     kl_type,
    output logic [ROW_W+COL_W-1:0]   kl_data,
    output logic [NUM_ROWS*NUM_COLS-1:0] kl_set,
    output logic                     init_done,
    output logic                     busy,
    output logic                     cmd_err,
    output logic [1:0]               state_dbg
);

    localparam int N      = NUM_ROWS * NUM_COLS;
    localparam int TAG_W  = ROW_W + COL_W;
    localparam int HOLD_W = (KEY_HOLD > 2) ? $clog2(KEY_HOLD) : 1;
    localparam logic [ROW_W-1:0]  ROW_MAX  = ROW_W'(NUM_ROWS - 1);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(NUM_COLS - 1);
    localparam logic [HOLD_W-1:0] HOLD_RLD = HOLD_W'(KEY_HOLD - 1);
    localparam logic [TAG_W-1:0]  NULL_TAG = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_READY = 2'd2,
        S_KEY   = 2'd3
    } kl_state_e;

    // Handshake: a command transfers on a rising clk edge where cmd_valid and
    // cmd_ready are both high; cmd_* are sampled only on that edge. init_start in
    // READY wins over a simultaneous cmd_valid, which is then not taken.
    kl_state_e         state_q, state_d;
    logic [ROW_W-1:0]  cur_row_q, cur_row_d;
    logic [COL_W-1:0]  cur_col_q, cur_col_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              bcast_q, bcast_d;
    logic              kl_type_q, kl_type_d;
    logic [TAG_W-1:0]  kl_data_q, kl_data_d;
    logic [N-1:0]      kl_set_q, kl_set_d;
    logic              init_done_q, init_done_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              cmd_err_q, cmd_err_d;

    logic req_bcast;
    logic cmd_ok;

`ifdef KL_DISPATCH_BCAST_EN
    assign req_bcast = cmd_bcast;
`else
    assign req_bcast = 1'b0;
`endif

    // A row sweep ignores cmd_col, so only the row has to be in range.
    assign cmd_ok = (cmd_row <= ROW_MAX) && (req_bcast || (cmd_col <= COL_MAX));

    always_comb begin
        state_d     = state_q;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;
        hold_d      = hold_q;
        bcast_d     = bcast_q;
        init_done_d = init_done_q;
        cmd_err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (init_start) begin
                    state_d     = S_INIT;
                    cur_row_d   = '0;
                    cur_col_d   = '0;
                    init_done_d = 1'b0;
                end
            end
            S_INIT: begin
                if (cur_col_q == COL_MAX) begin
                    cur_col_d = '0;
                    if (cur_row_q == ROW_MAX) begin
                        state_d     = S_READY;
                        init_done_d = 1'b1;
                    end else begin
                        cur_row_d = cur_row_q + 1'b1;
                    end
                end else begin
                    cur_col_d = cur_col_q + 1'b1;
                end
            end
            S_READY: begin
                if (init_start) begin
                    state_d     = S_INIT;
                    cur_row_d   = '0;
                    cur_col_d   = '0;
                    init_done_d = 1'b0;
                end else if (cmd_valid) begin
                    if (cmd_ok) begin
                        state_d   = S_KEY;
                        cur_row_d = cmd_row;
                        cur_col_d = req_bcast ? '0 : cmd_col;
                        hold_d    = HOLD_RLD;
                        bcast_d   = req_bcast;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            S_KEY: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else if (bcast_q && (cur_col_q != COL_MAX)) begin
                    cur_col_d = cur_col_q + 1'b1;
                    hold_d    = HOLD_RLD;
                end else begin
                    state_d = S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        kl_type_d   = (state_d != S_INIT);
        kl_data_d   = (state_d == S_INIT || state_d == S_KEY) ? {cur_row_d, cur_col_d} : NULL_TAG;
        kl_set_d    = '0;
        if (state_d == S_INIT)
            kl_set_d = (state_q == S_INIT) ? (kl_set_q << 1) : N'(1);
        cmd_ready_d = (state_d == S_READY);
        busy_d      = (state_d == S_INIT) || (state_d == S_KEY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            hold_q      <= '0;
            bcast_q     <= 1'b0;
            kl_type_q   <= 1'b1;
            kl_data_q   <= NULL_TAG;
            kl_set_q    <= '0;
            init_done_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
            hold_q      <= hold_d;
            bcast_q     <= bcast_d;
            kl_type_q   <= kl_type_d;
            kl_data_q   <= kl_data_d;
            kl_set_q    <= kl_set_d;
            init_done_q <= init_done_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign kl_type   = kl_type_q;
    assign kl_data   = kl_data_q;
    assign kl_set    = kl_set_q;
    assign init_done = init_done_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign cmd_err   = cmd_err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_kl_dispatcher.sv
// Directed bench for kl_dispatcher: vector table for the sweep and command flow,
// plus hand-written sequences for mid-sweep reset and (when enabled) row sweeps.
module tb_kl_dispatcher;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] S_KEY   = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       init_start = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_row = '0;
    logic [1:0] cmd_col = '0;
`ifdef KL_DISPATCH_BCAST_EN
    logic       cmd_bcast = 1'b0;
`endif
    logic       kl_type;
    logic [3:0] kl_data;
    logic [8:0] kl_set;
    logic       init_done;
    logic       busy;
    logic       cmd_err;
    logic [1:0] state_dbg;

    int n_chk  = 0;
    int n_pass = 0;

    kl_dispatcher dut (
        .clk(clk), .rst(rst), .init_start(init_start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_row(cmd_row), .cmd_col(cmd_col),
`ifdef KL_DISPATCH_BCAST_EN
        .cmd_bcast(cmd_bcast),
`endif
        .kl_type(kl_type), .kl_data(kl_data), .kl_set(kl_set),
        .init_done(init_done), .busy(busy), .cmd_err(cmd_err),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       i_init;
        logic       i_vld;
        logic [1:0] i_row;
        logic [1:0] i_col;
        logic       e_type;
        logic [3:0] e_data;
        logic [8:0] e_set;
        logic       e_done;
        logic       e_rdy;
        logic       e_busy;
        logic       e_err;
        logic [1:0] e_st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic i, input logic v, input logic [1:0] r, input logic [1:0] c,
                       input logic t, input logic [3:0] d, input logic [8:0] s, input logic dn,
                       input logic rd, input logic b, input logic e, input logic [1:0] st);
        vec_t x;
        x.i_init = i; x.i_vld = v; x.i_row = r; x.i_col = c;
        x.e_type = t; x.e_data = d; x.e_set = s; x.e_done = dn;
        x.e_rdy = rd; x.e_busy = b; x.e_err = e; x.e_st = st;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h required %h", name, idx, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input int idx, input logic t, input logic [3:0] d, input logic [8:0] s,
                           input logic dn, input logic rd, input logic b, input logic e,
                           input logic [1:0] st);
        chk("kl_type",   idx, 32'(kl_type),   32'(t));
        chk("kl_data",   idx, 32'(kl_data),   32'(d));
        chk("kl_set",    idx, 32'(kl_set),    32'(s));
        chk("init_done", idx, 32'(init_done), 32'(dn));
        chk("cmd_ready", idx, 32'(cmd_ready), 32'(rd));
        chk("busy",      idx, 32'(busy),      32'(b));
        chk("cmd_err",   idx, 32'(cmd_err),   32'(e));
        chk("state",     idx, 32'(state_dbg), 32'(st));
    endtask

    initial begin
        int cyc;
        bit seen;

        //   init vld row col | type data set  done rdy busy err state
        add(0, 1, 1, 2,  1, 4'hF, 9'h000, 0, 0, 0, 0, S_IDLE);
        add(0, 1, 1, 2,  1, 4'hF, 9'h000, 0, 0, 0, 0, S_IDLE);
        add(1, 0, 0, 0,  0, 4'h0, 9'h001, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h1, 9'h002, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h2, 9'h004, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h4, 9'h008, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h5, 9'h010, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h6, 9'h020, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h8, 9'h040, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h9, 9'h080, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'hA, 9'h100, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  1, 4'hF, 9'h000, 1, 1, 0, 0, S_READY);
        add(0, 1, 1, 2,  1, 4'h6, 9'h000, 1, 0, 1, 0, S_KEY);
        add(0, 0, 0, 0,  1, 4'h6, 9'h000, 1, 0, 1, 0, S_KEY);
        add(0, 0, 0, 0,  1, 4'hF, 9'h000, 1, 1, 0, 0, S_READY);
        add(0, 1, 3, 0,  1, 4'hF, 9'h000, 1, 1, 0, 1, S_READY);
        add(0, 0, 0, 0,  1, 4'hF, 9'h000, 1, 1, 0, 0, S_READY);
        add(0, 1, 0, 3,  1, 4'hF, 9'h000, 1, 1, 0, 1, S_READY);
        add(0, 1, 2, 2,  1, 4'hA, 9'h000, 1, 0, 1, 0, S_KEY);
        add(0, 1, 0, 0,  1, 4'hA, 9'h000, 1, 0, 1, 0, S_KEY);
        add(0, 1, 0, 0,  1, 4'hF, 9'h000, 1, 1, 0, 0, S_READY);
        add(0, 1, 0, 0,  1, 4'h0, 9'h000, 1, 0, 1, 0, S_KEY);
        add(0, 0, 0, 0,  1, 4'h0, 9'h000, 1, 0, 1, 0, S_KEY);
        add(0, 0, 0, 0,  1, 4'hF, 9'h000, 1, 1, 0, 0, S_READY);
        add(1, 1, 1, 1,  0, 4'h0, 9'h001, 0, 0, 1, 0, S_INIT);
        add(1, 0, 0, 0,  0, 4'h1, 9'h002, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h2, 9'h004, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h4, 9'h008, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h5, 9'h010, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h6, 9'h020, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h8, 9'h040, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'h9, 9'h080, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  0, 4'hA, 9'h100, 0, 0, 1, 0, S_INIT);
        add(0, 0, 0, 0,  1, 4'hF, 9'h000, 1, 1, 0, 0, S_READY);
        add(0, 1, 2, 1,  1, 4'h9, 9'h000, 1, 0, 1, 0, S_KEY);
        add(1, 0, 0, 0,  1, 4'h9, 9'h000, 1, 0, 1, 0, S_KEY);
        add(0, 0, 0, 0,  1, 4'hF, 9'h000, 1, 1, 0, 0, S_READY);

        // Reset values while rst is held low.
        tick();
        chk_all(-1, 1, 4'hF, 9'h000, 0, 0, 0, 0, S_IDLE);
        tick();
        rst = 1'b1;
        tick();

        for (int k = 0; k < vecs.size(); k++) begin
            init_start = vecs[k].i_init;
            cmd_valid  = vecs[k].i_vld;
            cmd_row    = vecs[k].i_row;
            cmd_col    = vecs[k].i_col;
            tick();
            chk_all(k, vecs[k].e_type, vecs[k].e_data, vecs[k].e_set, vecs[k].e_done,
                    vecs[k].e_rdy, vecs[k].e_busy, vecs[k].e_err, vecs[k].e_st);
        end
        init_start = 1'b0;
        cmd_valid  = 1'b0;

        // Reset arriving mid-sweep at i=4 must clear outputs without a clock edge.
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_set", 100, 32'(kl_set), 32'h010);
        chk("mid_data", 100, 32'(kl_data), 32'h5);
        #2;
        rst = 1'b0;
        #1;
        chk_all(101, 1, 4'hF, 9'h000, 0, 0, 0, 0, S_IDLE);
        tick();
        rst = 1'b1;
        tick();
        chk_all(102, 1, 4'hF, 9'h000, 0, 0, 0, 0, S_IDLE);

        // Full sweep again: init_done must first appear on the 10th cycle.
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        cyc  = 1;
        seen = init_done;
        while (!seen && cyc < 20) begin
            tick();
            cyc++;
            seen = init_done;
        end
        chk("done_seen", 103, 32'(seen), 32'h1);
        chk("done_cycle", 103, 32'(cyc), 32'd10);
        chk("done_ready", 103, 32'(cmd_ready), 32'h1);

`ifdef KL_DISPATCH_BCAST_EN
        begin
            logic [3:0] exp_tags[6];
            int busy_cnt;
            exp_tags = '{4'h8, 4'h8, 4'h9, 4'h9, 4'hA, 4'hA};
            cmd_valid = 1'b1;
            cmd_bcast = 1'b1;
            cmd_row   = 2'd2;
            cmd_col   = 2'd1;
            busy_cnt  = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                cmd_valid = 1'b0;
                cmd_bcast = 1'b0;
                chk("bc_data", 200 + k, 32'(kl_data), 32'(exp_tags[k]));
                chk("bc_type", 200 + k, 32'(kl_type), 32'h1);
                chk("bc_ready", 200 + k, 32'(cmd_ready), 32'h0);
                if (busy) busy_cnt++;
            end
            tick();
            chk("bc_busy_cnt", 206, 32'(busy_cnt), 32'd6);
            chk_all(207, 1, 4'hF, 9'h000, 1, 1, 0, 0, S_READY);
            cmd_valid = 1'b1;
            cmd_bcast = 1'b1;
            cmd_row   = 2'd3;
            tick();
            cmd_valid = 1'b0;
            cmd_bcast = 1'b0;
            chk_all(208, 1, 4'hF, 9'h000, 1, 1, 0, 1, S_READY);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
